result_demux: RTL and testbench
===============================

// Module: result_demux
// PURPOSE
// - Steers one 32-bit result stream to one of two destinations. in_sel=0 goes to port 0 (register-file writeback); in_sel=1 goes to port 1 (store/data path).
// - This is the inverse of the 2:1 operand select in front of the ALU: one source fans out to two sinks.
// - Each output has a one-entry registered holding slot with a valid/ready handshake, so one slow sink does not stall traffic to the other.
// - Per-port saturating transfer counters are provided for debug.
// PARAMETERS
// - DATA_W  32  width of the data path
// - TAG_W   5   width of the destination tag (register index or word offset)
// - CNT_W   16  width of each saturating transfer counter
// PORTS
// - clk         in   1       rising-edge clock
// - rst         in   1       reset; synchronous, active-high
// - in_valid    in   1       input beat is present
// - in_ready    out  1       block can accept the input beat this cycle
// - in_sel      in   1       destination select: 0 = port 0, 1 = port 1
// - in_data     in   DATA_W  result value
// - in_tag      in   TAG_W   destination tag; travels with the data
// - out0_valid  out  1       port 0 holding slot is full
// - out0_ready  in   1       port 0 sink accepts the beat
// - out0_data   out  DATA_W  port 0 data
// - out0_tag    out  TAG_W   port 0 tag
// - out1_valid  out  1       port 1 holding slot is full
// - out1_ready  in   1       port 1 sink accepts the beat
// - out1_data   out  DATA_W  port 1 data
// - out1_tag    out  TAG_W   port 1 tag
// - cnt0        out  CNT_W   number of completed port 0 output transfers, saturating
// - cnt1        out  CNT_W   number of completed port 1 output transfers, saturating
// BEHAVIOUR
// - Reset: all outN_valid=0, outN_data=0, outN_tag=0, cnt0=cnt1=0.
//   - Reset mid-operation discards any held beat. No output handshake completes in a reset cycle.
//   - in_ready is 0 while rst=1.
// - Each slot has two states, EMPTY and FULL.
//   - EMPTY->FULL on an input accept targeting that slot.
//   - FULL->EMPTY on outN_valid&&outN_ready with no new accept into that slot.
//   - FULL->FULL, with new data loaded, when a drain and an accept happen in the same cycle.
// - in_ready = !rst && (slot[in_sel] EMPTY || outN_ready of that slot).
//   - This is combinational from in_sel and outN_ready. The slot for the other port has no influence on it.
// - Accept: in_valid&&in_ready. On the next edge the selected slot loads in_data/in_tag and sets valid.
//   - Latency is exactly 1 cycle from accept to outN_valid=1.
// - Full throughput: 1 beat/cycle to one port while its sink holds ready=1.
// - Output stability: while outN_valid=1 and outN_ready=0, outN_data/outN_tag hold constant.
// - The non-selected slot is never modified by an accept.
// - Ordering: order is preserved within a port. There is no ordering guarantee across ports.
// - in_sel/in_data/in_tag are ignored when in_valid=0. An X on in_sel with in_valid=0 must not corrupt state.
// - Counters: cntN increments on each completed outN handshake.
//   - Saturation: the counter holds at 2^CNT_W-1; no wrap.
//   - Both counters may increment in the same cycle.
// - The block has no combinational path from in_* to outN_*. outputs are registered only.
// TESTING
// - T1 reset: drive rst=1 for 2 cycles, with in_valid=1 -> in_ready=0, out0_valid=out1_valid=0, cnt0=cnt1=0.
// - T2 single route: out0_ready=0, accept {sel=0,data=0xDEADBEEF,tag=5}
//   -> next cycle out0_valid=1, data=0xDEADBEEF, tag=5, out1_valid=0.
//   - Held 3 cycles stable; then raise ready -> cnt0=1.
// - T3 backpressure isolation: port 0 is FULL with out0_ready=0.
//   - in_sel=0 -> in_ready=0.
//   - in_sel=1, data=0x12345678 -> in_ready=1; next cycle out1_valid=1, port 0 unchanged.
// - T4 streaming: both readies=1; send 8 beats alternating sel 0/1 with data=i.
//   - Required: one accept per cycle, port 0 sees 0,2,4,6 and port 1 sees 1,3,5,7, cnt0=cnt1=4.
// - T5 simultaneous drain+load: port 0 FULL (0xA), out0_ready=1, accept sel=0 data=0xB
//   -> out0_valid stays 1, data=0xB next cycle, cnt0 +1.
// - T6 saturation/reset: CNT_W=4, 20 port 1 transfers -> cnt1=15.
//   - Assert rst with port 1 FULL -> next cycle out1_valid=0, cnt1=0.

Source files
------------

// File: rtl/result_demux.sv
// result_demux: steers one result stream to one of two sinks. Each sink has a
// one-entry registered holding slot with a valid/ready handshake. Each sink
// also has a saturating debug counter of completed transfers.
module result_demux #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sel,
    input  logic [DATA_W-1:0] in_data,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic [TAG_W-1:0]  out0_tag,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic [TAG_W-1:0]  out1_tag,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    slot_state_e       slot0_q, slot0_d;
    slot_state_e       slot1_q, slot1_d;
    logic [DATA_W-1:0] data0_q, data0_d;
    logic [DATA_W-1:0] data1_q, data1_d;
    logic [TAG_W-1:0]  tag0_q,  tag0_d;
    logic [TAG_W-1:0]  tag1_q,  tag1_d;
    logic [CNT_W-1:0]  cnt0_q,  cnt0_d;
    logic [CNT_W-1:0]  cnt1_q,  cnt1_d;

    logic sel_free;
    logic accept0, accept1;
    logic drain0, drain1;

    // Input handshake: only the selected slot decides whether the beat can enter.
    always_comb begin
        // NOTE: combinational blocks use blocking assignments and give every output a default first, so no latch is inferred.
        sel_free = 1'b0;
        if (in_sel) begin
            sel_free = (slot1_q == SLOT_EMPTY) || out1_ready;
        end else begin
            sel_free = (slot0_q == SLOT_EMPTY) || out0_ready;
        end
        in_ready = !rst && sel_free;
        // An unknown in_sel while in_valid=0 still yields no accept, as in_valid gates both.
        accept0  = in_valid && in_ready && !in_sel;
        accept1  = in_valid && in_ready &&  in_sel;
        drain0   = (slot0_q == SLOT_FULL) && out0_ready;
        drain1   = (slot1_q == SLOT_FULL) && out1_ready;
    end

    // Slot and counter next state: a same-cycle drain and load keeps the slot full with new data.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        data0_d = data0_q;
        data1_d = data1_q;
        tag0_d  = tag0_q;
        tag1_d  = tag1_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;

        if (accept0) begin
            slot0_d = SLOT_FULL;
            data0_d = in_data;
            tag0_d  = in_tag;
        end else if (drain0) begin
            slot0_d = SLOT_EMPTY;
        end

        if (accept1) begin
            slot1_d = SLOT_FULL;
            data1_d = in_data;
            tag1_d  = in_tag;
        end else if (drain1) begin
            slot1_d = SLOT_EMPTY;
        end

        if (drain0 && (cnt0_q != CNT_MAX)) cnt0_d = cnt0_q + CNT_W'(1);
        if (drain1 && (cnt1_q != CNT_MAX)) cnt1_d = cnt1_q + CNT_W'(1);
    end

    // State registers; reset discards held beats and clears counters before any handshake counts.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            slot0_q <= SLOT_EMPTY;
            slot1_q <= SLOT_EMPTY;
            data0_q <= '0;
            data1_q <= '0;
            tag0_q  <= '0;
            tag1_q  <= '0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            tag0_q  <= tag0_d;
            tag1_q  <= tag1_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign out0_valid = (slot0_q == SLOT_FULL);
    assign out1_valid = (slot1_q == SLOT_FULL);
    assign out0_data  = data0_q;
    assign out1_data  = data1_q;
    assign out0_tag   = tag0_q;
    assign out1_tag   = tag1_q;
    assign cnt0       = cnt0_q;
    assign cnt1       = cnt1_q;

endmodule

// File: tb/tb_result_demux.sv
// tb_result_demux: directed scenarios plus randomized traffic for result_demux.
// A per-port queue model (depth at most one) predicts handshakes, data and counters.
module tb_result_demux;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 5;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              in_sel;
    logic [DATA_W-1:0] in_data;
    logic [TAG_W-1:0]  in_tag;
    logic              out0_valid, out0_ready;
    logic [DATA_W-1:0] out0_data;
    logic [TAG_W-1:0]  out0_tag;
    logic              out1_valid, out1_ready;
    logic [DATA_W-1:0] out1_data;
    logic [TAG_W-1:0]  out1_tag;
    logic [CNT_W-1:0]  cnt0, cnt1;

    result_demux #(.DATA_W(DATA_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
        .in_data(in_data), .in_tag(in_tag),
        .out0_valid(out0_valid), .out0_ready(out0_ready),
        .out0_data(out0_data), .out0_tag(out0_tag),
        .out1_valid(out1_valid), .out1_ready(out1_ready),
        .out1_data(out1_data), .out1_tag(out1_tag),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: beats waiting at each sink, and transfer counts.
    logic [TAG_W+DATA_W-1:0] q0[$];
    logic [TAG_W+DATA_W-1:0] q1[$];
    int exp_cnt0 = 0;
    int exp_cnt1 = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic sel, input logic [DATA_W-1:0] d,
                         input logic [TAG_W-1:0] t, input logic r0, input logic r1);
        in_valid   = v;
        in_sel     = sel;
        in_data    = d;
        in_tag     = t;
        out0_ready = r0;
        out1_ready = r1;
    endtask

    // Check outputs against the model for the current inputs, then advance one clock.
    task automatic step();
        logic exp_rdy;
        logic do_push;
        #1;
        if (rst) exp_rdy = 1'b0;
        else if (in_sel === 1'b1) exp_rdy = (q1.size() == 0) || out1_ready;
        else exp_rdy = (q0.size() == 0) || out0_ready;
        if (!$isunknown(in_sel) || rst) check("in_ready", 64'(in_ready), 64'(exp_rdy));
        check("out0_valid", 64'(out0_valid), 64'(q0.size() != 0));
        check("out1_valid", 64'(out1_valid), 64'(q1.size() != 0));
        if (q0.size() != 0) begin
            check("out0_data", 64'(out0_data), 64'(q0[0][DATA_W-1:0]));
            check("out0_tag",  64'(out0_tag),  64'(q0[0][TAG_W+DATA_W-1:DATA_W]));
        end
        if (q1.size() != 0) begin
            check("out1_data", 64'(out1_data), 64'(q1[0][DATA_W-1:0]));
            check("out1_tag",  64'(out1_tag),  64'(q1[0][TAG_W+DATA_W-1:DATA_W]));
        end
        check("cnt0", 64'(cnt0), 64'(exp_cnt0));
        check("cnt1", 64'(cnt1), 64'(exp_cnt1));

        if (rst) begin
            q0.delete();
            q1.delete();
            exp_cnt0 = 0;
            exp_cnt1 = 0;
        end else begin
            do_push = (in_valid === 1'b1) && exp_rdy;
            if (q0.size() != 0 && out0_ready) begin
                void'(q0.pop_front());
                if (exp_cnt0 < CMAX) exp_cnt0++;
            end
            if (q1.size() != 0 && out1_ready) begin
                void'(q1.pop_front());
                if (exp_cnt1 < CMAX) exp_cnt1++;
            end
            if (do_push) begin
                if (in_sel) q1.push_back({in_tag, in_data});
                else        q0.push_back({in_tag, in_data});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h1, 5'd1, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // T1: reset held two cycles with in_valid=1.
        step();
        step();
        check("rst_out0_data", 64'(out0_data), 64'd0);
        check("rst_out0_tag",  64'(out0_tag),  64'd0);
        check("rst_out1_data", 64'(out1_data), 64'd0);
        check("rst_out1_tag",  64'(out1_tag),  64'd0);
        rst = 1'b0;

        // T2: single route to port 0, held while the sink stalls.
        drive(1'b1, 1'b0, 32'hDEADBEEF, 5'd5, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        repeat (3) step();
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        step();
        step();
        check("t2_cnt0", 64'(cnt0), 64'd1);

        // T3: port 0 stalled full does not block port 1.
        drive(1'b1, 1'b0, 32'h00001111, 5'd1, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b0, 32'h00002222, 5'd2, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b1, 32'h12345678, 5'd7, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        step();
        check("t3_out1_data", 64'(out1_data), 64'h12345678);
        check("t3_out0_data", 64'(out0_data), 64'h00001111);
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
        step();
        step();

        // T4: streaming alternating ports at one beat per cycle.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i[0], 32'(i), 5'(i), 1'b1, 1'b1);
            step();
        end
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
        step();
        check("t4_cnt0", 64'(cnt0), 64'd4);
        check("t4_cnt1", 64'(cnt1), 64'd4);

        // T5: drain and reload port 0 in the same cycle.
        do_reset();
        drive(1'b1, 1'b0, 32'hA, 5'd2, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b0, 32'hB, 5'd3, 1'b1, 1'b0);
        step();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        step();
        check("t5_out0_valid", 64'(out0_valid), 64'd1);
        check("t5_out0_data",  64'(out0_data),  64'hB);
        check("t5_cnt0",       64'(cnt0),       64'd1);

        // T6: counter saturation, then reset with port 1 full.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 32'(i), 5'(i), 1'b0, 1'b1);
            step();
        end
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        step();
        check("t6_cnt1_sat", 64'(cnt1), 64'd15);
        drive(1'b1, 1'b1, 32'h55, 5'd4, 1'b0, 1'b0);
        step();
        rst = 1'b1;
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        step();
        rst = 1'b0;
        check("t6_out1_valid", 64'(out1_valid), 64'd0);
        check("t6_cnt1_rst",   64'(cnt1),       64'd0);

        // Unknown select with no valid beat must leave both slots untouched.
        drive(1'b1, 1'b0, 32'h77, 5'd9, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b1, 32'h88, 5'd10, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'bx, 32'hFFFFFFFF, 5'd31, 1'b0, 1'b0);
        repeat (3) step();
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
        step();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom, 5'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
            step();
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
